// File: rtl/dram_pkg.sv
// dram_pkg: shared types, field positions, function codes and parity helper
// for the 512x15 instruction dispatch RAM (DRAM).
// Spec bit numbering is MSB-first (bit 0 = MSB); SV index = 14 - spec bit.
// Word layout: [0:2] A, [3:5] B, [6] PAR, [7:10] J[1:4], [11:14] J[7:10].
package dram_pkg;

  typedef logic [14:0] dramWord_t;
  typedef logic [8:0]  dramAddr_t;

  localparam int unsigned DRAM_A_LSB   = 12;  // A  occupies [14:12]
  localparam int unsigned DRAM_B_LSB   = 9;   // B  occupies [11:9]
  localparam int unsigned DRAM_PAR_BIT = 8;   // PAR
  localparam int unsigned DRAM_J1_LSB  = 4;   // J[1:4]  occupies [7:4]
  localparam int unsigned DRAM_J7_LSB  = 0;   // J[7:10] occupies [3:0]

  typedef enum logic [2:0] {
    DRAM_LD_XY_EVEN = 3'b000,
    DRAM_LD_XY_ODD  = 3'b001,
    DRAM_LD_JCOM    = 3'b010,
    DRAM_LD_J7_EVEN = 3'b011,
    DRAM_LD_J7_ODD  = 3'b100,
    DRAM_COMMIT     = 3'b101,
    DRAM_CLR_FLAGS  = 3'b110,
    DRAM_LD_NOP     = 3'b111
  } dramFunc_e;

  // PAR value that makes the XOR of all 15 bits equal 1. The PAR slot of the
  // argument is ignored, so a stored word can be rechecked by comparing its
  // PAR bit against this result.
  function automatic logic dram_odd_par(input dramWord_t w);
    dramWord_t m;
    m = w;
    m[DRAM_PAR_BIT] = 1'b0;
    return ~(^m);
  endfunction

endpackage

// File: rtl/dram_word_stage.sv
// dram_word_stage: staging registers for one DRAM word (A, B, J7, parinv)
// plus parity generation. The shared J[1:4] field comes from the parent.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_ld_ab      load A=ebus[0:2], B=ebus[3:5]
//   i_ld_j7      load J7=ebus[2:5], parinv=ebus[0]
//   i_ebus       EBUS data bits 0:5 (bit 0 = MSB = i_ebus[5])
//   i_jcom       shared J[1:4] field
//   o_word       assembled 15-bit word with PAR
module dram_word_stage
  import dram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ld_ab,
  input  logic        i_ld_j7,
  input  logic [5:0]  i_ebus,
  input  logic [3:0]  i_jcom,
  output logic [14:0] o_word
);

  logic [2:0]  r_a;
  logic [2:0]  r_b;
  logic [3:0]  r_j7;
  logic        r_parinv;
  dramWord_t   w_body;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_j7     <= '0;
      r_parinv <= 1'b0;
    end else begin
      if (i_ld_ab) begin
        r_a <= i_ebus[5:3];
        r_b <= i_ebus[2:0];
      end
      if (i_ld_j7) begin
        r_j7     <= i_ebus[3:0];
        r_parinv <= i_ebus[5];
      end
    end
  end

  always_comb begin
    w_body = '0;
    w_body[DRAM_A_LSB +: 3]  = r_a;
    w_body[DRAM_B_LSB +: 3]  = r_b;
    w_body[DRAM_J1_LSB +: 4] = i_jcom;
    w_body[DRAM_J7_LSB +: 4] = r_j7;
    o_word = w_body;
    // parinv deliberately breaks parity for fault-injection diagnostics
    o_word[DRAM_PAR_BIT] = dram_odd_par(w_body) ^ r_parinv;
  end

endmodule

// File: rtl/dram_loader.sv
// dram_loader: diagnostic writer for the 512x15 DRAM. Stages fields from
// EBUS load functions 06x for an even/odd address pair and, on COMMIT,
// writes both words; optionally reads them back and compares.
// Optional feature macro: DRAM_READBACK_VERIFY_EN (readback verify states).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_strobe           function present this cycle
//   diag_func             function select (DIAG[4:6])
//   ebus_data             EBUS data bits 0:5 (bit 0 = MSB)
//   pair_addr             DRAM pair address (LSB ignored)
//   dram_addr/din/we      DRAM write port
//   dram_dout             DRAM read data, one-cycle latency
//   busy, done            sequence in progress / completion pulse
//   err_busy, verify_fail sticky error flags
//   pair_count            committed pairs, wraps
module dram_loader
  import dram_pkg::*;
#(
  parameter int DRAM_WIDTH     = 15,
  parameter int DRAM_ADDR_BITS = 9,
  parameter int CNT_BITS       = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_strobe,
  input  logic [2:0]                diag_func,
  input  logic [5:0]                ebus_data,
  input  logic [DRAM_ADDR_BITS-1:0] pair_addr,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic [DRAM_WIDTH-1:0]     dram_din,
  output logic                      dram_we,
  input  logic [DRAM_WIDTH-1:0]     dram_dout,
  output logic                      busy,
  output logic                      done,
  output logic                      err_busy,
  output logic                      verify_fail,
  output logic [CNT_BITS-1:0]       pair_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_EVEN = 3'd1,
    ST_WR_ODD  = 3'd2
`ifdef DRAM_READBACK_VERIFY_EN
    ,
    ST_RD_EVEN = 3'd3,
    ST_RD_ODD  = 3'd4,
    ST_CMP     = 3'd5
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  dramFunc_e             w_func;
  logic                  w_cmd;
  logic                  w_last;
  logic [3:0]            r_jcom;
  dramAddr_t             r_pa;
  dramWord_t             r_snap_even;
  dramWord_t             r_snap_odd;
  dramWord_t             w_even_word;
  dramWord_t             w_odd_word;
  logic                  r_done;
  logic                  r_err_busy;
  logic                  r_verify_fail;
  logic [CNT_BITS-1:0]   r_pair_count;
  logic                  w_unused_bits;

  assign w_func = dramFunc_e'(diag_func);
  assign w_cmd  = load_strobe && (r_state == ST_IDLE);
  assign w_unused_bits = ^{dram_dout, pair_addr[0]};

  dram_word_stage u_even (
    .clk     (clk),
    .reset   (reset),
    .i_ld_ab (w_cmd && (w_func == DRAM_LD_XY_EVEN)),
    .i_ld_j7 (w_cmd && (w_func == DRAM_LD_J7_EVEN)),
    .i_ebus  (ebus_data),
    .i_jcom  (r_jcom),
    .o_word  (w_even_word)
  );

  dram_word_stage u_odd (
    .clk     (clk),
    .reset   (reset),
    .i_ld_ab (w_cmd && (w_func == DRAM_LD_XY_ODD)),
    .i_ld_j7 (w_cmd && (w_func == DRAM_LD_J7_ODD)),
    .i_ebus  (ebus_data),
    .i_jcom  (r_jcom),
    .o_word  (w_odd_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_cmd && (w_func == DRAM_COMMIT)) w_next = ST_WR_EVEN;
      ST_WR_EVEN: w_next = ST_WR_ODD;
`ifdef DRAM_READBACK_VERIFY_EN
      ST_WR_ODD:  w_next = ST_RD_EVEN;
      ST_RD_EVEN: w_next = ST_RD_ODD;
      ST_RD_ODD:  w_next = ST_CMP;
      ST_CMP:     w_next = ST_IDLE;
`else
      ST_WR_ODD:  w_next = ST_IDLE;
`endif
      default:    w_next = ST_IDLE;
    endcase
  end

`ifdef DRAM_READBACK_VERIFY_EN
  assign w_last = (r_state == ST_CMP);
`else
  assign w_last = (r_state == ST_WR_ODD);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_jcom        <= '0;
      r_pa          <= '0;
      r_snap_even   <= '0;
      r_snap_odd    <= '0;
      r_done        <= 1'b0;
      r_err_busy    <= 1'b0;
      r_verify_fail <= 1'b0;
      r_pair_count  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (w_last) r_pair_count <= r_pair_count + 1'b1;
      if (load_strobe && (r_state != ST_IDLE)) begin
        r_err_busy <= 1'b1;
      end else if (w_cmd && (w_func == DRAM_CLR_FLAGS)) begin
        r_err_busy    <= 1'b0;
        r_verify_fail <= 1'b0;
      end
      if (w_cmd && (w_func == DRAM_LD_JCOM)) r_jcom <= ebus_data[3:0];
      if (w_cmd && (w_func == DRAM_COMMIT)) begin
        r_pa        <= {pair_addr[8:1], 1'b0};
        r_snap_even <= w_even_word;
        r_snap_odd  <= w_odd_word;
      end
`ifdef DRAM_READBACK_VERIFY_EN
      // dram_dout lags the address by one cycle: even data arrives in RD_ODD
      if ((r_state == ST_RD_ODD) && (dram_dout != r_snap_even)) r_verify_fail <= 1'b1;
      if ((r_state == ST_CMP)    && (dram_dout != r_snap_odd))  r_verify_fail <= 1'b1;
`endif
    end
  end

  always_comb begin
    dram_we   = 1'b0;
    dram_din  = '0;
    dram_addr = '0;
    case (r_state)
      ST_WR_EVEN: begin
        dram_we   = 1'b1;
        dram_din  = r_snap_even;
        dram_addr = r_pa;
      end
      ST_WR_ODD: begin
        dram_we   = 1'b1;
        dram_din  = r_snap_odd;
        dram_addr = {r_pa[8:1], 1'b1};
      end
`ifdef DRAM_READBACK_VERIFY_EN
      ST_RD_EVEN: dram_addr = r_pa;
      ST_RD_ODD:  dram_addr = {r_pa[8:1], 1'b1};
`endif
      default: ;
    endcase
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign err_busy    = r_err_busy;
  assign pair_count  = r_pair_count;
`ifdef DRAM_READBACK_VERIFY_EN
  assign verify_fail = r_verify_fail;
`else
  assign verify_fail = 1'b0;
`endif

endmodule

// File: tb/tb_dram_loader.sv
module tb_dram_loader;

`ifdef DRAM_READBACK_VERIFY_EN
  localparam int LAST = 5;
  localparam bit VER  = 1'b1;
`else
  localparam int LAST = 2;
  localparam bit VER  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_strobe = 1'b0;
  logic [2:0]  diag_func = '0;
  logic [5:0]  ebus_data = '0;
  logic [8:0]  pair_addr = '0;
  logic [8:0]  dram_addr;
  logic [14:0] dram_din;
  logic        dram_we;
  logic [14:0] dram_dout = '0;
  logic        busy, done, err_busy, verify_fail;
  logic [8:0]  pair_count;

  dram_loader #(.DRAM_WIDTH(15), .DRAM_ADDR_BITS(9), .CNT_BITS(9)) dut (
    .clk(clk), .reset(reset), .load_strobe(load_strobe), .diag_func(diag_func),
    .ebus_data(ebus_data), .pair_addr(pair_addr), .dram_addr(dram_addr),
    .dram_din(dram_din), .dram_we(dram_we), .dram_dout(dram_dout),
    .busy(busy), .done(done), .err_busy(err_busy), .verify_fail(verify_fail),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DRAM model with optional corruption of odd-word spec bit 14 on readback
  logic [14:0] mem [0:511];
  bit corrupt = 1'b0;
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr] <= dram_din;
    dram_dout <= mem[dram_addr] ^ ((corrupt && dram_addr[0]) ? 15'h0001 : 15'h0000);
  end

  // Behavioural model: field values as integers, words built arithmetically
  int          m_seq = -1;
  int          m_cnt = 0;
  bit          m_err = 0, m_vf = 0, m_done = 0, m_corrupt = 0, was_busy;
  int          ea = 0, eb = 0, oa = 0, ob = 0, jc = 0, ej = 0, oj = 0;
  bit          ep = 0, op = 0;
  logic [8:0]  m_pa = '0;
  logic [14:0] m_we = '0, m_wo = '0;

  function automatic logic [14:0] build(input int a, input int b, input int j, input int j7, input bit pinv);
    int w;
    w = (a << 12) + (b << 9) + (j << 4) + j7;
    if ((($countones(w[14:0]) % 2) == 0) != pinv) w = w + 256;
    return w[14:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_seq = -1; m_cnt = 0; m_err = 0; m_vf = 0; m_done = 0;
      ea = 0; eb = 0; oa = 0; ob = 0; jc = 0; ej = 0; oj = 0; ep = 0; op = 0;
    end else begin
      was_busy = (m_seq >= 0);
      m_done = 0;
      if (m_seq == LAST) begin
        m_seq = -1; m_done = 1; m_cnt = (m_cnt + 1) % 512;
        if (VER && m_corrupt) m_vf = 1;
      end else if (m_seq >= 1) m_seq++;
      if (load_strobe) begin
        if (was_busy) m_err = 1;
        else case (diag_func)
          3'd0: begin ea = ebus_data[5:3]; eb = ebus_data[2:0]; end
          3'd1: begin oa = ebus_data[5:3]; ob = ebus_data[2:0]; end
          3'd2: jc = ebus_data[3:0];
          3'd3: begin ej = ebus_data[3:0]; ep = ebus_data[5]; end
          3'd4: begin oj = ebus_data[3:0]; op = ebus_data[5]; end
          3'd5: begin
            m_pa = pair_addr & 9'h1FE;
            m_we = build(ea, eb, jc, ej, ep);
            m_wo = build(oa, ob, jc, oj, op);
            m_seq = 1;
            m_corrupt = corrupt;
          end
          3'd6: begin m_err = 0; m_vf = 0; end
          default: ;
        endcase
      end
    end
  end

  // Single compare process, every cycle once reset has been applied
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, m_seq >= 0);
      chk("done", done, m_done);
      chk("we", dram_we, (m_seq == 1) || (m_seq == 2));
      chk("din", dram_din, (m_seq == 1) ? m_we : (m_seq == 2) ? m_wo : 15'h0);
      if (m_seq == 1 || m_seq == 3) chk("addr_even", dram_addr, m_pa);
      if (m_seq == 2 || m_seq == 4) chk("addr_odd", dram_addr, m_pa | 9'h001);
      chk("err_busy", err_busy, m_err);
      chk("pair_count", pair_count, m_cnt);
      if (m_seq < 0) chk("verify_fail", verify_fail, m_vf);
    end
  end

  task automatic strobe(input logic [2:0] f, input logic [5:0] d);
    diag_func = f; ebus_data = d; load_strobe = 1'b1;
    @(posedge clk); #1;
    load_strobe = 1'b0;
  endtask

  task automatic commit(input logic [8:0] pa);
    pair_addr = pa;
    strobe(3'd5, 6'h00);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; return; end
    end
    chk("done_timeout", 0, 1);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_count", pair_count, 0);
    reset = 1'b0;

    // Main pair write at 0x13F
    strobe(3'd0, 6'h2A); strobe(3'd1, 6'h1E); strobe(3'd2, 6'h0A);
    strobe(3'd3, 6'h03); strobe(3'd4, 6'h0C);
    commit(9'h13F);
    @(negedge clk);
    chk("t1_we", dram_we, 1); chk("t1_addr", dram_addr, 9'h13E); chk("t1_even", dram_din, 15'h54A3);
    @(negedge clk);
    chk("t2_addr", dram_addr, 9'h13F); chk("t2_odd", dram_din, 15'h3DAC);
    wait_done(n);
    chk("done_latency", n, LAST - 1);
    chk("count1", pair_count, 1);

    // Parity fault injection on the even word
    strobe(3'd3, 6'h23);
    commit(9'h020);
    @(negedge clk);
    chk("pinv_even", dram_din, 15'h55A3); chk("pinv_even_par", ^dram_din, 0);
    @(negedge clk);
    chk("pinv_odd_par", ^dram_din, 1);
    wait_done(n);

    // Strobe while busy is ignored and flagged
    commit(9'h040);
    strobe(3'd0, 6'h3F);
    wait_done(n);
    chk("err_set", err_busy, 1);
    commit(9'h060);
    @(negedge clk);
    chk("staging_kept", dram_din, 15'h55A3);
    wait_done(n);
    strobe(3'd6, 6'h00);
    @(negedge clk);
    chk("err_clr", err_busy, 0);

    // Readback corruption on odd word
    corrupt = 1'b1;
    commit(9'h080);
    wait_done(n);
    chk("vf_set", verify_fail, VER);
    corrupt = 1'b0;
    strobe(3'd6, 6'h00);
    @(negedge clk);
    chk("vf_clr", verify_fail, 0);

    // Reset in WR_EVEN
    commit(9'h0A0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", dram_we, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_cnt", pair_count, 0);
    commit(9'h000);
    @(negedge clk);
    chk("rst_staging", dram_din, 15'h0100);
    wait_done(n);

    // Counter wrap
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 512; i++) begin
      commit(i[8:0]);
      wait_done(n);
    end
    chk("wrap", pair_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_loader.md
Name: dram_loader

Overview:
- Diagnostic writer for the 512x15 instruction dispatch RAM (DRAM); the write-side counterpart of the IR board's DRAM read path.
- Accepts EBUS diagnostic load functions 06x and stages A/B/J/parity fields for an even/odd DRAM address pair.
- On a commit function it sequences two DRAM write cycles, producing the address, data and write-enable that drive the DRAM write port.
- Sits beside the IR board, between the CTL diagnostic decode and the DRAM.

Parameters:
- DRAM_WIDTH, 15, DRAM word width (fixed layout below).
- DRAM_ADDR_BITS, 9, DRAM address width.
- CNT_BITS, 9, width of the committed-pair counter.

Ports:
- clk  input  1  DRAM write clock.
- reset  input  1  synchronous, active-high.
- load_strobe  input  1  one-cycle pulse; a DIAG_LOAD_FUNC_06x function is present this cycle.
- diag_func  input  3  DIAG[4:6] function select.
- ebus_data  input  6  EBUS data bits 0:5.
- pair_addr  input  9  DRAM pair address; bit 8 is ignored.
- dram_addr  output  9  DRAM address.
- dram_din  output  15  DRAM write data.
- dram_we  output  1  DRAM write enable.
- dram_dout  input  15  DRAM read data; one-cycle synchronous latency.
- busy  output  1  write or verify sequence in progress.
- done  output  1  one-cycle pulse when a sequence completes.
- err_busy  output  1  sticky; a strobe arrived while busy.
- verify_fail  output  1  sticky; readback mismatch. Held 0 when the optional feature is compiled out.
- pair_count  output  CNT_BITS  number of committed pairs, wraps modulo 2^CNT_BITS.

Behaviour:
- Word layout, bit 0 is MSB: [0:2] A, [3:5] B, [6] PAR, [7:10] J[1:4], [11:14] J[7:10].
- Function decode, applied only when load_strobe=1 and the FSM is IDLE:
  - 000: even A=ebus[0:2], even B=ebus[3:5].
  - 001: odd A/B, same mapping as 000.
  - 010: J common=ebus[2:5], shared by both words.
  - 011: even J7=ebus[2:5], even parinv=ebus[0].
  - 100: odd J7/parinv, same mapping as 011.
  - 101: COMMIT.
  - 110: clear err_busy and verify_fail.
  - 111: no-op.
- PAR bit is computed so the XOR of all 15 bits equals 1 (odd parity), then inverted when parinv=1 (fault injection).
- Staging registers persist after commit, so partial reloads are allowed.
- FSM states: IDLE, WR_EVEN, WR_ODD, then RD_EVEN, RD_ODD, CMP when verify is compiled in, then back to IDLE.
- COMMIT sampled in cycle T:
  - pair address latched, bit 8 forced to 0; staged words are snapshotted.
  - T+1 WR_EVEN: dram_we=1, addr={pa[0:7],0}, din=even word.
  - T+2 WR_ODD: dram_we=1, addr={pa[0:7],1}, din=odd word.
  - Without verify: T+3 IDLE, done=1, pair_count increments.
- busy=1 in every state except IDLE. dram_we=1 only in WR_EVEN and WR_ODD. dram_din=0 when dram_we=0.
- A strobe while busy is ignored, including 110; err_busy is set.
- Reset at any cycle, including mid-sequence:
  - FSM returns to IDLE; no further dram_we.
  - All staging registers, flags and pair_count go to 0.
  - All outputs reset to 0.
- Setting a sticky flag and clearing it (110) cannot occur in the same cycle, because 110 is ignored while busy.

Optional Feature:
- DRAM_READBACK_VERIFY_EN defined:
  - T+3 RD_EVEN: addr=even, we=0.
  - T+4 RD_ODD: addr=odd; dram_dout compared with the even snapshot.
  - T+5 CMP: dram_dout compared with the odd snapshot.
  - Any mismatch sets verify_fail.
  - T+6 IDLE with done=1 and pair_count increment.
- Undefined: RD/CMP states are absent and verify_fail is tied to 0.

Decomposition:
- Shared package dram_pkg:
  - typedef dramWord_t (15-bit) and dramAddr_t (9-bit).
  - field position constants.
  - function-code enum DRAM_LD_XY_EVEN..DRAM_LD_NOP.
  - odd-parity function, reusable by the IR read-side parity check.
- Sub-module dram_word_stage: holds the A/B/J/parinv registers for one word plus its parity generation. Instantiated twice (even, odd); the J common register stays in the top.

Test Plan:
- Stage even A=5 B=2, odd A=3 B=6, J common=0xA, even J7=0x3, odd J7=0xC, then COMMIT at pair 0x13F → T+1 we=1 addr 0x13E with correct word and PAR; T+2 addr 0x13F; done at T+3 (T+6 with verify); pair_count=1.
- Stage even word with parinv=1 and commit → written even word has even overall parity; odd word has odd parity.
- Strobe 000 while busy → staging unchanged, err_busy=1; then 110 in IDLE → err_busy=0.
- Reset asserted at WR_EVEN → no dram_we at T+2; busy=0, pair_count=0, staging all 0.
- Verify build, with the DRAM model corrupting odd-word bit 14 → verify_fail=1 at completion; done still pulses once.
- 512 consecutive commits → pair_count wraps to 0.
